// File: rtl/float_mon_pkg.sv
// Shared types and IEEE 754 single-precision field constants for the settle monitor.
package float_mon_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fclass_t;

endpackage

// File: rtl/ieee754_classify.sv
// Combinational IEEE 754 single-precision classifier; the sign bit plays no part.
module ieee754_classify
  import float_mon_pkg::*;
(
  input  logic [31:0] word_i,
  output fclass_t     class_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             unused_sign;

  assign exp_f       = word_i[30:23];
  assign man_f       = word_i[22:0];
  assign unused_sign = word_i[31];

  always_comb begin
    class_o = CLS_NORMAL;
    if (exp_f == '0) begin
      class_o = (man_f == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (exp_f == EXP_W'(EXP_MAX)) begin
      class_o = (man_f == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/float_settle_monitor.sv
// Waits for a float input to repeat STABLE_CNT times (or for TIMEOUT cycles),
// then holds the captured sample, its class and the cycle count until consumed.
module float_settle_monitor
  import float_mon_pkg::*;
#(
  parameter int STABLE_CNT = 20,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 10
) (
  input  logic             clk_100k,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      sample_in,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [31:0]      res_value,
  output logic             res_stable,
  output logic [2:0]       res_class,
  output logic [CNT_W-1:0] res_cycles,
  output state_t           dbg_state_o
);

  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Handshake: res_valid is high for the whole HOLD state; the result is
  // consumed on the first rising edge where res_valid and res_ready are both 1.

  state_t           state_q, state_d;
  logic [31:0]      prev_q, prev_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [31:0]      res_value_q, res_value_d;
  logic             res_stable_q, res_stable_d;
  fclass_t          res_class_q, res_class_d;
  logic [CNT_W-1:0] res_cycles_q, res_cycles_d;

  fclass_t          sample_class;
  logic             match;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] elapsed_inc;

  ieee754_classify u_classify (
    .word_i  (sample_in),
    .class_o (sample_class)
  );

  assign match       = (sample_in == prev_q);
  assign run_inc     = run_q + CNT_W'(1);
  assign elapsed_inc = elapsed_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    elapsed_d    = elapsed_q;
    res_value_d  = res_value_q;
    res_stable_d = res_stable_q;
    res_class_d  = res_class_q;
    res_cycles_d = res_cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prev_d    = sample_in;
          run_d     = '0;
          elapsed_d = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        elapsed_d = elapsed_inc;
        prev_d    = sample_in;
        run_d     = match ? run_inc : '0;
        // Settling is tested first so a simultaneous timeout reports as stable.
        if (match && (run_inc == STABLE_C)) begin
          res_value_d  = sample_in;
          res_class_d  = sample_class;
          res_stable_d = 1'b1;
          res_cycles_d = elapsed_inc;
          state_d      = ST_HOLD;
        end else if (elapsed_inc == TIMEOUT_C) begin
          res_value_d  = sample_in;
          res_class_d  = sample_class;
          res_stable_d = 1'b0;
          res_cycles_d = TIMEOUT_C;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100k or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      run_q        <= '0;
      elapsed_q    <= '0;
      res_value_q  <= '0;
      res_stable_q <= 1'b0;
      res_class_q  <= CLS_ZERO;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      elapsed_q    <= elapsed_d;
      res_value_q  <= res_value_d;
      res_stable_q <= res_stable_d;
      res_class_q  <= res_class_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_HOLD);
  assign res_value   = res_value_q;
  assign res_stable  = res_stable_q;
  assign res_class   = res_class_q;
  assign res_cycles  = res_cycles_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_float_settle_monitor.sv
// Directed and randomized checks of float_settle_monitor against a sequence-level reference model.
module tb_float_settle_monitor;

  localparam int STABLE_CNT = 20;
  localparam int TIMEOUT    = 1000;
  localparam int CNT_W      = 10;
  localparam int SEQ_LEN    = 1100;

  logic             clk_100k;
  logic             reset_n;
  logic             start;
  logic [31:0]      sample_in;
  logic             res_ready;
  logic             busy;
  logic             res_valid;
  logic [31:0]      res_value;
  logic             res_stable;
  logic [2:0]       res_class;
  logic [CNT_W-1:0] res_cycles;
  logic [1:0]       dbg_state;

  int vectors;
  int miscompares;

  // seq[0] is the sample seen on the start edge, seq[k] the sample on SETTLE edge k.
  logic [31:0] seq [0:SEQ_LEN-1];

  float_settle_monitor #(
    .STABLE_CNT (STABLE_CNT),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_100k    (clk_100k),
    .reset_n     (reset_n),
    .start       (start),
    .sample_in   (sample_in),
    .res_ready   (res_ready),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_value   (res_value),
    .res_stable  (res_stable),
    .res_class   (res_class),
    .res_cycles  (res_cycles),
    .dbg_state_o (dbg_state)
  );

  initial clk_100k = 1'b0;
  always #5 clk_100k = ~clk_100k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_class(input logic [31:0] w);
    int e;
    int m;
    e = int'((w >> 23) & 32'hFF);
    m = int'(w & 32'h007F_FFFF);
    if (e == 0)   return (m == 0) ? 32'd0 : 32'd1;
    if (e == 255) return (m == 0) ? 32'd3 : 32'd4;
    return 32'd2;
  endfunction

  // Walk the sample sequence: count repeats, settle at STABLE_CNT repeats,
  // otherwise give up at TIMEOUT cycles.
  task automatic ref_model(output int cyc, output logic stable, output logic [31:0] val);
    int run;
    run = 0;
    cyc = TIMEOUT;
    stable = 1'b0;
    val = seq[TIMEOUT];
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (seq[k] == seq[k-1]) run++;
      else run = 0;
      if (run == STABLE_CNT) begin
        cyc = k;
        stable = 1'b1;
        val = seq[k];
        return;
      end
    end
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int k = 0; k < SEQ_LEN; k++) seq[k] = v;
  endtask

  function automatic logic [31:0] rand_word(input int kind);
    logic [31:0] w;
    w = $urandom;
    case (kind)
      0: w = {w[31], 31'd0};
      1: w = {w[31], 8'd0, 22'd0, 1'b1} | {9'd0, w[22:0]};
      2: w = {w[31], 8'($urandom_range(1, 254)), w[22:0]};
      3: w = {w[31], 8'hFF, 23'd0};
      default: w = {w[31], 8'hFF, w[22:1], 1'b1};
    endcase
    return w;
  endfunction

  task automatic fill_random(input int flip_pct);
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] cur;
    v0 = rand_word($urandom_range(0, 4));
    v1 = v0 ^ (32'd1 << $urandom_range(0, 31));
    cur = v0;
    seq[0] = cur;
    for (int k = 1; k < SEQ_LEN; k++) begin
      if ($urandom_range(0, 99) < flip_pct) cur = (cur == v0) ? v1 : v0;
      seq[k] = cur;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ev, input logic es,
                              input int ec);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_value"}, res_value, ev);
    check({tag, "_stable"}, 32'(res_stable), 32'(es));
    check({tag, "_class"}, 32'(res_class), ref_class(ev));
    check({tag, "_cycles"}, 32'(res_cycles), 32'(ec));
  endtask

  // One measurement over seq[]; res_ready stays low for hold_cycles edges of HOLD
  // while start is pulsed randomly, then the result is consumed.
  task automatic do_measure(input string tag, input int hold_cycles);
    int          exp_cyc;
    logic        exp_stable;
    logic [31:0] exp_val;
    int          k;
    bit          got;
    ref_model(exp_cyc, exp_stable, exp_val);
    @(negedge clk_100k);
    start = 1'b1;
    sample_in = seq[0];
    res_ready = (hold_cycles == 0);
    @(posedge clk_100k); #1;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < TIMEOUT + 5) begin
      k++;
      @(negedge clk_100k);
      start = 1'b0;
      sample_in = seq[k];
      @(posedge clk_100k); #1;
      if (res_valid) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_cyc));
    if (!got) return;
    check_result(tag, exp_val, exp_stable, exp_cyc);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk_100k);
      start = 1'($urandom_range(0, 1));
      sample_in = $urandom;
      @(posedge clk_100k); #1;
      check_result({tag, "_hold"}, exp_val, exp_stable, exp_cyc);
    end
    @(negedge clk_100k);
    res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk_100k); #1;
    check({tag, "_release_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_release_busy"}, 32'(busy), 32'd0);
    @(negedge clk_100k);
    start = 1'b0;
    @(posedge clk_100k); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start = 1'b0;
    sample_in = 32'h0;
    res_ready = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_value", res_value, 32'd0);
    check("rst_stable", 32'(res_stable), 32'd0);
    check("rst_class", 32'(res_class), 32'd0);
    check("rst_cycles", 32'(res_cycles), 32'd0);
    @(negedge clk_100k);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_100k);

    // Constant normal sample settles in STABLE_CNT edges
    fill_const(32'h3F80_0000);
    do_measure("const_one", 0);

    // Toggling sample never settles
    for (int k = 0; k < SEQ_LEN; k++) seq[k] = (k % 2 == 0) ? 32'h4000_0000 : 32'h4000_0001;
    do_measure("toggle_timeout", 0);

    // Change at SETTLE cycle 10 restarts the run
    for (int k = 0; k < SEQ_LEN; k++) seq[k] = (k < 10) ? 32'h4049_0FDB : 32'h7F80_0000;
    do_measure("restart_inf", 0);

    // Class sweep
    fill_const(32'h0000_0000); do_measure("cls_pzero", 0);
    fill_const(32'h8000_0000); do_measure("cls_nzero", 0);
    fill_const(32'h0000_0001); do_measure("cls_denorm", 0);
    fill_const(32'h7FC0_0000); do_measure("cls_nan", 0);
    fill_const(32'hC2C8_0000); do_measure("cls_normal", 0);

    // Frozen HOLD with start pulses, then release
    fill_const(32'h4120_0000);
    do_measure("hold_freeze", 50);

    // Randomized measurements
    for (int n = 0; n < 12; n++) begin
      int pct;
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 2;
        2: pct = 8;
        default: pct = 60;
      endcase
      fill_random(pct);
      do_measure("rand", $urandom_range(0, 3));
    end

    // Reset during SETTLE discards the measurement
    fill_const(32'h3F80_0000);
    @(negedge clk_100k);
    start = 1'b1;
    sample_in = seq[0];
    res_ready = 1'b1;
    @(negedge clk_100k);
    start = 1'b0;
    repeat (6) @(negedge clk_100k);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_value", res_value, 32'd0);
    check("midrst_stable", 32'(res_stable), 32'd0);
    check("midrst_class", 32'(res_class), 32'd0);
    check("midrst_cycles", 32'(res_cycles), 32'd0);
    repeat (2) @(negedge clk_100k);
    reset_n = 1'b1;
    for (int i = 0; i < STABLE_CNT + 10; i++) begin
      @(posedge clk_100k); #1;
      check("postrst_valid", 32'(res_valid), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end

    // A fresh start works after the reset
    do_measure("postrst_measure", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/float_settle_monitor.md
FLOAT_SETTLE_MONITOR -- requirements
Module: float_settle_monitor

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 20, meaning consecutive identical samples that declare the input settled.
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the maximum number of SETTLE cycles before forced capture.
REQ-003 SHALL have parameter CNT_W, default 10, meaning the width of the run and elapsed counters; TIMEOUT < 2**CNT_W.
REQ-004 clk_100k  input  1  measurement clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a measurement window.
REQ-007 sample_in  input  32  IEEE 754 single-precision word from the upstream converter.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 busy  output  1  high in SETTLE or HOLD.
REQ-010 res_valid  output  1  result available (HOLD state).
REQ-011 res_value  output  32  captured sample.
REQ-012 res_stable  output  1  1 = settled, 0 = timeout.
REQ-013 res_class  output  3  0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 NAN.
REQ-014 res_cycles  output  CNT_W  number of SETTLE cycles spent.

Function
REQ-015 SHALL implement the states IDLE, SETTLE and HOLD.
REQ-016 In IDLE, start=1 SHALL load prev<=sample_in, run<=0, elapsed<=0, and move to SETTLE; start=0 SHALL keep IDLE.
REQ-017 In SETTLE, each edge SHALL do elapsed<=elapsed+1 and prev<=sample_in.
REQ-018 In SETTLE, sample_in==prev SHALL increment run, and any mismatch SHALL clear run to 0.
REQ-019 When a match makes run+1==STABLE_CNT, the block SHALL capture sample_in into res_value, set res_stable=1, set res_cycles=elapsed+1, and move to HOLD.
REQ-020 Otherwise, when elapsed+1==TIMEOUT, the block SHALL capture sample_in, set res_stable=0, set res_cycles=TIMEOUT, and move to HOLD.
REQ-021 Stable and timeout in the same cycle SHALL resolve as stable (res_stable=1).
REQ-022 HOLD SHALL hold res_valid=1 and keep all res_* outputs constant until res_ready=1, then move to IDLE on that edge.
REQ-023 start SHALL be ignored in SETTLE and HOLD, including the HOLD->IDLE cycle.
REQ-024 res_class SHALL be registered with res_value and computed from exp=[30:23] and man=[22:0] as follows:
- exp=0, man=0: ZERO
- exp=0, man!=0: DENORM
- exp=255, man=0: INF
- exp=255, man!=0: NAN
- otherwise: NORMAL
REQ-025 The sign bit SHALL NOT affect res_class; -0.0 (0x80000000) SHALL classify as ZERO.
REQ-026 Minimum latency from start to res_valid SHALL be STABLE_CNT edges.
REQ-027 Counters SHALL NOT wrap, because the TIMEOUT bound is reached first.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, with busy=0, res_valid=0, res_value=0, res_stable=0, res_class=0, res_cycles=0, and prev, run and elapsed all 0.
REQ-029 Reset asserted mid-SETTLE or mid-HOLD SHALL discard the measurement, and no res_valid SHALL follow reset release without a new start.
REQ-030 Deassertion of reset_n SHALL be synchronized to clk_100k by the upstream clock generator; this block SHALL add no synchronizer.

Structure
REQ-031 Package float_mon_pkg SHALL hold:
- the state enum
- the class enum (ZERO..NAN)
- EXP_W=8, MAN_W=23, EXP_MAX=255
REQ-032 Classification SHALL be a combinational sub-module named ieee754_classify (32-bit in, 3-bit class out), instantiated once.
REQ-033 No other sub-modules SHALL be instantiated.

Verification
REQ-034 Constant sample 0x3F800000, start pulse, res_ready=1 -> res_valid 20 edges after start; res_value=0x3F800000, res_stable=1, res_class=NORMAL, res_cycles=20.
REQ-035 Sample toggling 0x40000000/0x40000001 every edge, TIMEOUT=1000 -> res_valid after 1000 edges with res_stable=0 and res_cycles=1000.
REQ-036 Sample changes at SETTLE cycle 10, then constant 0x7F800000 -> run restarts; res_valid at cycle 30, res_class=INF, res_cycles=30.
REQ-037 Class sweep with 0x00000000, 0x80000000, 0x00000001, 0x7FC00000 and 0xC2C80000 -> ZERO, ZERO, DENORM, NAN, NORMAL respectively.
REQ-038 res_ready=0 for 50 edges in HOLD with start pulses -> outputs frozen, start ignored; res_ready=1 -> IDLE on the next edge.
REQ-039 reset_n low at SETTLE cycle 7 -> all outputs 0 immediately; after release, no res_valid until a new start.
